// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Data-memory responder for the MEM stage of an RV32IM pipeline. Serves
// byte/half/word loads and stores out of word-addressed storage. It holds
// BUSYWAIT high for a fixed ACCESS_LATENCY cycles per access, then spends one
// DONE cycle with BUSYWAIT low while the load result is presented.
//
// Parameters
//   DEPTH_WORDS    storage depth in 32-bit words (power of two, >= 4)
//   ACCESS_LATENCY cycles BUSYWAIT is high per access (1..15)
//
// Ports
//   CLK         in   clock, rising edge
//   RESET       in   asynchronous active-low reset
//   READ_WRITE  in   [3:0]  access code, 4'b0000 = no request
//   ADDRESS     in   [31:0] byte address (upper bits alias)
//   WRITE_DATA  in   [31:0] store data (low byte/half for SB/SH)
//   READ_DATA   out  [31:0] registered, extended load result
//   BUSYWAIT    out  stall request to the pipeline registers
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH_WORDS    = 256,
    parameter int ACCESS_LATENCY = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  READ_WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_count;
    logic [3:0]         r_code;
    logic [IDX_W-1:0]   r_index;
    logic [1:0]         r_lane;
    logic [31:0]        r_wdata;
    logic [31:0]        r_read_data;
    logic [31:0]        r_mem [0:DEPTH_WORDS-1];

    logic               w_legal;
    logic               w_req;
    logic               w_in_idle;
    logic               w_commit;
    logic [3:0]         w_code;
    logic [IDX_W-1:0]   w_index;
    logic [1:0]         w_lane;
    logic [31:0]        w_wdata;
    logic               w_is_store;
    logic               w_is_load;
    logic [31:0]        w_old;
    logic [31:0]        w_store_data;
    logic [3:0]         w_byte_en;
    logic [31:0]        w_merged;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load_value;
    logic               w_unused;

    // Address bits above the word index only alias; they are deliberately dropped.
    assign w_unused = ^ADDRESS[31:IDX_W+2];

    always_comb begin
        w_legal = 1'b0;
        case (READ_WRITE)
            4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101,
            4'b0001, 4'b0010, 4'b0011: w_legal = 1'b1;
            default:                   w_legal = 1'b0;
        endcase
    end

    // No request may be accepted while reset is held.
    assign w_req     = RESET & w_legal;
    assign w_in_idle = (r_state == S_IDLE);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_next = (ACCESS_LATENCY == 1) ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_count == 4'd0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        BUSYWAIT = (w_in_idle && w_req) || (r_state == S_ACCESS);
    end

    // Request latch and latency counter. The counter is loaded with
    // LATENCY-2 because the IDLE cycle already counts as one busy cycle and
    // the ACCESS cycle with count 0 is the last one.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_count <= 4'd0;
            r_code  <= 4'd0;
            r_index <= '0;
            r_lane  <= 2'd0;
            r_wdata <= 32'd0;
        end else if (w_in_idle && w_req) begin
            r_count <= (ACCESS_LATENCY > 1) ? 4'(ACCESS_LATENCY - 2) : 4'd0;
            r_code  <= READ_WRITE;
            r_index <= ADDRESS[IDX_W+1:2];
            r_lane  <= ADDRESS[1:0];
            r_wdata <= WRITE_DATA;
        end else if (r_state == S_ACCESS && r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
        end
    end

    // With ACCESS_LATENCY=1 the commit edge is the IDLE acceptance edge, so
    // the live inputs are used there; otherwise the latched request is used.
    assign w_code   = w_in_idle ? READ_WRITE          : r_code;
    assign w_index  = w_in_idle ? ADDRESS[IDX_W+1:2]  : r_index;
    assign w_lane   = w_in_idle ? ADDRESS[1:0]        : r_lane;
    assign w_wdata  = w_in_idle ? WRITE_DATA          : r_wdata;

    assign w_commit = (w_in_idle && w_req && (ACCESS_LATENCY == 1)) ||
                      (r_state == S_ACCESS && r_count == 4'd0);
    // Only legal codes reach commit, and every legal load has bit 3 set.
    assign w_is_load  = w_code[3];
    assign w_is_store = ~w_code[3];

    assign w_old = r_mem[w_index];

    // Store lane enables and lane-replicated store data.
    always_comb begin
        w_byte_en    = 4'b0000;
        w_store_data = w_wdata;
        case (w_code)
            4'b0001: begin
                w_byte_en    = 4'b0001 << w_lane;
                w_store_data = {4{w_wdata[7:0]}};
            end
            4'b0010: begin
                w_byte_en    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_store_data = {2{w_wdata[15:0]}};
            end
            4'b0011: begin
                w_byte_en    = 4'b1111;
                w_store_data = w_wdata;
            end
            default: begin
                w_byte_en    = 4'b0000;
                w_store_data = w_wdata;
            end
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_merged[8*gi +: 8] = w_byte_en[gi] ? w_store_data[8*gi +: 8]
                                                   : w_old[8*gi +: 8];
    end

    // Load extraction and extension.
    assign w_byte = w_old[{w_lane, 3'b000} +: 8];
    assign w_half = w_old[{w_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_load_value = w_old;
        case (w_code)
            4'b1000: w_load_value = {{24{w_byte[7]}}, w_byte};
            4'b1001: w_load_value = {{16{w_half[15]}}, w_half};
            4'b1100: w_load_value = {24'd0, w_byte};
            4'b1101: w_load_value = {16'd0, w_half};
            default: w_load_value = w_old;
        endcase
    end

    // Storage is never cleared by reset. A reset during an access forces
    // IDLE asynchronously, so w_commit cannot fire for that access.
    always_ff @(posedge CLK) begin
        if (w_commit && w_is_store) begin
            r_mem[w_index] <= w_merged;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_read_data <= 32'd0;
        end else if (w_commit && w_is_load) begin
            r_read_data <= w_load_value;
        end
    end

    assign READ_DATA = r_read_data;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed bench for data_mem_responder. Instance 0 uses ACCESS_LATENCY=3,
// instance 1 uses ACCESS_LATENCY=1; both use DEPTH_WORDS=256. A table of
// requests with hand-computed stall patterns and READ_DATA values is applied
// in order, followed by hand-written reset-during-access sequences.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  rw   [2];
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic [31:0] rd   [2];
    logic        busy [2];

    int n_vec  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    data_mem_responder #(.DEPTH_WORDS(256), .ACCESS_LATENCY(3)) dut0 (
        .CLK        (CLK),
        .RESET      (RESET),
        .READ_WRITE (rw[0]),
        .ADDRESS    (addr[0]),
        .WRITE_DATA (wdat[0]),
        .READ_DATA  (rd[0]),
        .BUSYWAIT   (busy[0])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .ACCESS_LATENCY(1)) dut1 (
        .CLK        (CLK),
        .RESET      (RESET),
        .READ_WRITE (rw[1]),
        .ADDRESS    (addr[1]),
        .WRITE_DATA (wdat[1]),
        .READ_DATA  (rd[1]),
        .BUSYWAIT   (busy[1])
    );

    typedef struct {
        int          sel;
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] wd;
        logic        stall;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int sel, input logic [3:0] code, input logic [31:0] a,
                           input logic [31:0] wd, input logic stall, input logic [31:0] exp_rd);
        vec_t v;
        v.sel = sel; v.code = code; v.a = a; v.wd = wd; v.stall = stall; v.exp_rd = exp_rd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // One transaction: present the request right after a rising edge, hold it
    // through DONE, record BUSYWAIT at each falling edge, check READ_DATA in
    // the DONE cycle, then drop the request and confirm no second stall.
    task automatic run_req(input string tag, input int sel, input logic [3:0] code,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic stall, input logic [31:0] exp_rd);
        int          lat;
        logic [15:0] got_mask;
        logic [15:0] want_mask;
        logic [31:0] rd_done;
        lat = (sel == 1) ? 1 : 3;
        @(posedge CLK); #1;
        rw[sel] = code; addr[sel] = a; wdat[sel] = wd;
        got_mask = 16'd0;
        rd_done  = 32'd0;
        for (int k = 0; k <= lat; k++) begin
            @(negedge CLK);
            got_mask[k] = busy[sel];
            if (k == lat) rd_done = rd[sel];
        end
        want_mask = stall ? ((16'd1 << lat) - 16'd1) : 16'd0;
        chk({tag, " busy pattern"}, {16'd0, got_mask}, {16'd0, want_mask});
        chk({tag, " read_data"}, rd_done, exp_rd);
        @(posedge CLK); #1;
        rw[sel] = 4'b0000;
        @(negedge CLK);
        chk({tag, " no restall"}, {31'd0, busy[sel]}, 32'd0);
        $display("dut%0d %s code=%b addr=%h wdata=%h busy=%b read_data=%h",
                 sel, tag, code, a, wd, got_mask[3:0], rd_done);
    endtask

    initial begin
        RESET = 1'b0;
        for (int s = 0; s < 2; s++) begin
            rw[s] = 4'b0000; addr[s] = 32'd0; wdat[s] = 32'd0;
        end

        // ACCESS_LATENCY=3 instance
        add_vec(0, 4'b0011, 32'h10,  32'hDEADBEEF, 1, 32'h00000000); // SW
        add_vec(0, 4'b1010, 32'h10,  32'h0,        1, 32'hDEADBEEF); // LW
        add_vec(0, 4'b0001, 32'h13,  32'h12345680, 1, 32'hDEADBEEF); // SB
        add_vec(0, 4'b1000, 32'h13,  32'h0,        1, 32'hFFFFFF80); // LB
        add_vec(0, 4'b1100, 32'h13,  32'h0,        1, 32'h00000080); // LBU
        add_vec(0, 4'b1010, 32'h10,  32'h0,        1, 32'h80ADBEEF); // LW
        add_vec(0, 4'b1000, 32'h11,  32'h0,        1, 32'hFFFFFFBE); // LB lane1
        add_vec(0, 4'b1001, 32'h10,  32'h0,        1, 32'hFFFFBEEF); // LH low
        add_vec(0, 4'b0011, 32'h20,  32'h11111111, 1, 32'hFFFFBEEF); // SW
        add_vec(0, 4'b0010, 32'h22,  32'h5A5A8234, 1, 32'hFFFFBEEF); // SH
        add_vec(0, 4'b1001, 32'h22,  32'h0,        1, 32'hFFFF8234); // LH
        add_vec(0, 4'b1101, 32'h23,  32'h0,        1, 32'h00008234); // LHU, bit0 ignored
        add_vec(0, 4'b1010, 32'h20,  32'h0,        1, 32'h82341111); // LW
        add_vec(0, 4'b1101, 32'h21,  32'h0,        1, 32'h00001111); // LHU low half
        add_vec(0, 4'b1100, 32'h22,  32'h0,        1, 32'h00000034); // LBU lane2
        add_vec(0, 4'b0011, 32'h400, 32'hA5A5A5A5, 1, 32'h00000034); // SW wraps to word 0
        add_vec(0, 4'b1010, 32'h0,   32'h0,        1, 32'hA5A5A5A5); // LW aliased
        add_vec(0, 4'b1111, 32'h0,   32'h0,        0, 32'hA5A5A5A5); // illegal
        add_vec(0, 4'b0100, 32'h0,   32'hFFFFFFFF, 0, 32'hA5A5A5A5); // illegal store-ish
        add_vec(0, 4'b1011, 32'h0,   32'h0,        0, 32'hA5A5A5A5); // illegal load-ish
        add_vec(0, 4'b1010, 32'h0,   32'h0,        1, 32'hA5A5A5A5); // memory unchanged
        // ACCESS_LATENCY=1 instance
        add_vec(1, 4'b0011, 32'h8,   32'hCAFEF00D, 1, 32'h00000000); // SW
        add_vec(1, 4'b1010, 32'h8,   32'h0,        1, 32'hCAFEF00D); // LW
        add_vec(1, 4'b1000, 32'hB,   32'h0,        1, 32'hFFFFFFCA); // LB
        add_vec(1, 4'b1101, 32'h9,   32'h0,        1, 32'h0000F00D); // LHU
        add_vec(1, 4'b0000, 32'h8,   32'h0,        0, 32'h0000F00D); // no request

        // Reset state
        repeat (2) @(posedge CLK);
        #2;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("dut%0d reset busy", s), {31'd0, busy[s]}, 32'd0);
            chk($sformatf("dut%0d reset read_data", s), rd[s], 32'd0);
        end
        #1 RESET = 1'b1;

        foreach (vecs[i]) begin
            run_req($sformatf("vec%0d", i), vecs[i].sel, vecs[i].code, vecs[i].a,
                    vecs[i].wd, vecs[i].stall, vecs[i].exp_rd);
        end

        // Reset mid-ACCESS of a load: outputs clear at once, load never lands.
        @(posedge CLK); #1;
        rw[0] = 4'b1010; addr[0] = 32'h10;
        @(negedge CLK);
        chk("rst-load cycle0 busy", {31'd0, busy[0]}, 32'd1);
        @(posedge CLK); #2;
        RESET = 1'b0; rw[0] = 4'b0000;
        #1;
        chk("rst-load busy async", {31'd0, busy[0]}, 32'd0);
        chk("rst-load read_data async", rd[0], 32'd0);
        @(posedge CLK); #3;
        RESET = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            chk("rst-load idle busy", {31'd0, busy[0]}, 32'd0);
        end
        chk("rst-load read_data kept", rd[0], 32'd0);
        $display("dut0 reset during LW 0x10: busy=%b read_data=%h", busy[0], rd[0]);

        // Reset during a store: the word keeps its old contents.
        run_req("sw-old", 0, 4'b0011, 32'h0, 32'h12345678, 1, 32'h00000000);
        @(posedge CLK); #1;
        rw[0] = 4'b0011; addr[0] = 32'h0; wdat[0] = 32'h55555555;
        @(posedge CLK); #1;
        RESET = 1'b0; rw[0] = 4'b0000;
        @(negedge CLK);
        chk("rst-store busy", {31'd0, busy[0]}, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        $display("dut0 reset during SW 0x0 <= 55555555");
        run_req("lw-after-rst", 0, 4'b1010, 32'h0, 32'h0, 1, 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
